// File: rtl/spi_bit_receiver.sv
// SPI mode-0 front end: synchronises sclk/mosi/cs_n into clk and produces
// per-bit strobes, frame-start clears, word-boundary strobes and frame status.
module spi_bit_receiver #(
    parameter int WORD_WIDTH   = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int WCOUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    mosi,
    input  logic                    cs_n,
    output logic                    bit_out,
    output logic                    bit_enable,
    output logic                    sipo_clear,
    output logic                    word_boundary,
    output logic                    frame_active,
    output logic                    frame_done,
    output logic                    frame_error,
    output logic [7:0]              bit_count,
    output logic [WCOUNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_sync_vld;
    logic                   r_sclk_d, r_cs_d;
    logic                   w_sclk_s, w_mosi_s, w_cs_s;
    logic                   w_rise, w_cs_fall;

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk_s & ~r_sclk_d;
    assign w_cs_fall = ~w_cs_s & r_cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sync_vld  <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= w_sclk_s;
            // cs_d only tracks cs_s once the chain holds real samples, so a
            // cs_n already low at reset release never looks like a fall.
            r_cs_d      <= r_sync_vld[SYNC_STAGES-1] ? w_cs_s : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_next = ACTIVE;
            ACTIVE:  if (w_cs_s)    w_next = CLOSE;
            CLOSE:                  w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    assign frame_active = (r_state == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_out       <= 1'b0;
            bit_enable    <= 1'b0;
            sipo_clear    <= 1'b0;
            word_boundary <= 1'b0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
            bit_count     <= '0;
            word_count    <= '0;
        end else begin
            bit_enable    <= 1'b0;
            sipo_clear    <= 1'b0;
            word_boundary <= 1'b0;
            frame_done    <= 1'b0;
            case (r_state)
                IDLE: if (w_cs_fall) begin
                    sipo_clear  <= 1'b1;
                    bit_count   <= '0;
                    word_count  <= '0;
                    frame_error <= 1'b0;
                end
                // cs going high wins over a coincident sclk rise
                ACTIVE: if (!w_cs_s && w_rise) begin
                    bit_enable <= 1'b1;
                    bit_out    <= w_mosi_s;
                    if (bit_count == 8'(WORD_WIDTH-1)) begin
                        bit_count     <= '0;
                        word_boundary <= 1'b1;
                        if (word_count != '1) word_count <= word_count + 1'b1;
                    end else begin
                        bit_count <= bit_count + 8'd1;
                    end
                end
                CLOSE: begin
                    frame_done  <= 1'b1;
                    frame_error <= (bit_count != 8'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bit_receiver.sv
// Randomised bench for spi_bit_receiver: drives SPI frames and compares the
// observed strobes/counters against a simple per-frame bit-list model.
module tb_spi_bit_receiver;
    localparam int WW = 32;

    logic clk = 0, rst = 1, sclk = 0, mosi = 0, cs_n = 1;
    logic bit_out, bit_enable, sipo_clear, word_boundary;
    logic frame_active, frame_done, frame_error;
    logic [7:0]  bit_count;
    logic [15:0] word_count;

    spi_bit_receiver #(.WORD_WIDTH(WW), .SYNC_STAGES(2), .WCOUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .bit_out(bit_out), .bit_enable(bit_enable), .sipo_clear(sipo_clear),
        .word_boundary(word_boundary), .frame_active(frame_active),
        .frame_done(frame_done), .frame_error(frame_error),
        .bit_count(bit_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit tx[$];
    bit rx_bits[$], rx_wb[$];
    int clr_cnt, done_cnt, early_en, overlap, act_seen;

    // Record what the DUT emits; tasks compare against the model afterwards.
    always @(negedge clk) if (!rst) begin
        if (bit_enable) begin
            rx_bits.push_back(bit_out);
            rx_wb.push_back(word_boundary);
            if (clr_cnt == 0) early_en++;
        end
        if (sipo_clear) clr_cnt++;
        if (frame_done) done_cnt++;
        if (sipo_clear && bit_enable) overlap++;
        if (word_boundary && !bit_enable) overlap++;
        if (frame_active) act_seen = 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_bits.delete(); rx_wb.delete();
        clr_cnt = 0; done_cnt = 0; early_en = 0; overlap = 0; act_seen = 0;
    endtask

    // Send tx[] inside one cs_n-low frame; collide puts the cs_n rise on the last sclk rise.
    task automatic run_frame(input bit collide);
        clear_mon();
        cs_n = 0; cyc(6);
        foreach (tx[i]) begin
            mosi = tx[i]; cyc(4);
            if (collide && i == tx.size()-1) cs_n = 1;
            sclk = 1; cyc(4);
            sclk = 0;
        end
        if (!collide) begin cyc(4); cs_n = 1; end
        cyc(8);
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) tx.push_back(w[i]);
    endtask

    task automatic test_reset();
        cyc(1);
        total++;
        if ({bit_out, bit_enable, sipo_clear, word_boundary, frame_active, frame_done,
             frame_error, bit_count, word_count} !== '0) begin
            bad++; $display("FAIL reset_in: outputs not zero during reset");
        end
        rst = 0; cyc(4);
        total++;
        if ({bit_out, bit_enable, sipo_clear, word_boundary, frame_active, frame_done,
             frame_error, bit_count, word_count} !== '0) begin
            bad++; $display("FAIL reset_out: outputs not zero after reset");
        end
    endtask

    task automatic test_frame32();
        int errs = 0, wberr = 0;
        tx.delete(); load_word(32'hA5C3_0F01);
        run_frame(0);
        total++;
        if (rx_bits.size() != 32) begin bad++; $display("FAIL f32_count got=%0d exp=32", rx_bits.size()); end
        foreach (rx_bits[i]) if (i < 32 && (rx_bits[i] !== tx[i] || rx_wb[i] !== (i == 31))) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL f32_data got=%0d bad bits exp=0", errs); end
        total++;
        if (clr_cnt != 1 || early_en != 0 || overlap != 0) begin
            bad++; $display("FAIL f32_clear clr=%0d early=%0d ovl=%0d exp=1,0,0", clr_cnt, early_en, overlap);
        end
        total++;
        if (done_cnt != 1 || act_seen != 1 || frame_active !== 0) begin
            bad++; $display("FAIL f32_done done=%0d act=%0d exp=1,1", done_cnt, act_seen);
        end
        total++;
        if (word_count !== 16'd1 || bit_count !== 8'd0 || frame_error !== 0) begin
            bad++; $display("FAIL f32_counts wc=%0d bc=%0d err=%0b exp=1,0,0", word_count, bit_count, frame_error);
        end
        wberr = 0;
    endtask

    task automatic test_frame64();
        int errs = 0;
        tx.delete(); load_word(32'h1); load_word(32'hFFFF_FFFF);
        run_frame(0);
        foreach (tx[i]) if (i >= rx_bits.size() || rx_bits[i] !== tx[i] ||
                            rx_wb[i] !== (i % WW == WW-1)) errs++;
        total++;
        if (errs != 0 || rx_bits.size() != 64) begin
            bad++; $display("FAIL f64_data got=%0d bad, n=%0d exp=0, 64", errs, rx_bits.size());
        end
        total++;
        if (word_count !== 16'd2 || frame_error !== 0 || done_cnt != 1) begin
            bad++; $display("FAIL f64_counts wc=%0d err=%0b done=%0d exp=2,0,1", word_count, frame_error, done_cnt);
        end
    endtask

    task automatic test_partial();
        tx.delete();
        for (int i = 0; i < 12; i++) tx.push_back(1'($urandom));
        run_frame(0);
        total++;
        if (bit_count !== 8'd12 || word_count !== 0 || frame_error !== 1 || done_cnt != 1) begin
            bad++; $display("FAIL partial bc=%0d wc=%0d err=%0b done=%0d exp=12,0,1,1",
                            bit_count, word_count, frame_error, done_cnt);
        end
        cs_n = 0; cyc(6);
        total++;
        if (frame_error !== 0 || bit_count !== 0) begin
            bad++; $display("FAIL partial_clr err=%0b bc=%0d exp=0,0", frame_error, bit_count);
        end
        cs_n = 1; cyc(8);
    endtask

    task automatic test_no_cs();
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom); cyc(4); sclk = 1; cyc(4); sclk = 0;
        end
        cyc(6);
        total++;
        if (rx_bits.size() != 0 || clr_cnt != 0 || done_cnt != 0 || bit_count !== 0 || word_count !== 0) begin
            bad++; $display("FAIL no_cs en=%0d clr=%0d done=%0d bc=%0d", rx_bits.size(), clr_cnt, done_cnt, bit_count);
        end
    endtask

    task automatic test_midreset();
        clear_mon();
        cs_n = 0; cyc(6);
        for (int i = 0; i < 5; i++) begin mosi = 1; cyc(4); sclk = 1; cyc(4); sclk = 0; end
        cyc(2); rst = 1; cyc(2); rst = 0;
        clear_mon();
        for (int i = 0; i < 8; i++) begin mosi = 1; cyc(4); sclk = 1; cyc(4); sclk = 0; end
        cyc(4);
        total++;
        if (rx_bits.size() != 0 || clr_cnt != 0 || act_seen != 0 ||
            {bit_out, frame_error, bit_count, word_count} !== '0) begin
            bad++; $display("FAIL midreset en=%0d clr=%0d act=%0d bc=%0d", rx_bits.size(), clr_cnt, act_seen, bit_count);
        end
        cs_n = 1; cyc(8);
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(1'($urandom));
        run_frame(0);
        total++;
        if (rx_bits.size() != 8 || bit_count !== 8'd8 || frame_error !== 1) begin
            bad++; $display("FAIL midreset_fresh en=%0d bc=%0d err=%0b exp=8,8,1", rx_bits.size(), bit_count, frame_error);
        end
    endtask

    task automatic test_collide();
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(1'($urandom));
        run_frame(1);
        total++;
        if (rx_bits.size() != 19 || bit_count !== 8'd19 || frame_error !== 1 || done_cnt != 1) begin
            bad++; $display("FAIL collide en=%0d bc=%0d err=%0b exp=19,19,1", rx_bits.size(), bit_count, frame_error);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            int n, errs;
            n = $urandom_range(1, 80);
            tx.delete();
            for (int i = 0; i < n; i++) tx.push_back(1'($urandom));
            run_frame(0);
            errs = 0;
            foreach (tx[i]) if (i >= rx_bits.size() || rx_bits[i] !== tx[i] ||
                                rx_wb[i] !== (i % WW == WW-1)) errs++;
            total++;
            if (errs != 0 || rx_bits.size() != n) begin
                bad++; $display("FAIL rand_data n=%0d got=%0d bad=%0d", n, rx_bits.size(), errs);
            end
            total++;
            if (word_count !== 16'(n / WW) || bit_count !== 8'(n % WW) ||
                frame_error !== (n % WW != 0) || clr_cnt != 1 || done_cnt != 1 || overlap != 0) begin
                bad++; $display("FAIL rand_counts n=%0d wc=%0d bc=%0d err=%0b clr=%0d done=%0d",
                                n, word_count, bit_count, frame_error, clr_cnt, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame32();
        test_frame64();
        test_partial();
        test_no_cs();
        test_midreset();
        test_collide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
